relu_seq_ctrl: RTL and testbench
================================

Name: relu_seq_ctrl

Overview:
- Sequencer that applies ReLU to one flattened 6x6 feature map of 16-bit signed values.
- Reads elements from a source buffer read port with 1-cycle latency, clamps negatives to zero, and writes results to a destination buffer write port that has backpressure.
- Sits between the convolution output buffer and the pooling input buffer; the top-level FSM drives it with a start/done handshake.

Parameters:
- DATA_W, 16, element width, two's-complement signed.
- NUM_ELEM, 36, elements per feature map.
- ADDR_W, 6, buffer address width; must satisfy 2^ADDR_W >= NUM_ELEM.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses (inclusive).
- done  out  1  one-cycle pulse after the last write is accepted.
- src_rd_en  out  1  source read strobe.
- src_rd_addr  out  ADDR_W  source element index.
- src_rd_data  in  DATA_W  source data; valid the cycle after src_rd_en.
- dst_wr_en  out  1  destination write valid.
- dst_wr_addr  out  ADDR_W  destination element index.
- dst_wr_data  out  DATA_W  ReLU result.
- dst_ready  in  1  destination accepts a write when dst_wr_en && dst_ready.
- neg_count  out  ADDR_W  number of elements clipped in the last pass; held until the next start.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0: busy, done, src_rd_en, src_rd_addr, dst_wr_en, dst_wr_addr, dst_wr_data, neg_count.
  - Read counter, write counter, pipeline valids and skid buffer are cleared.
  - Reset mid-pass aborts the pass. No done pulse is issued, and partial destination contents are undefined.
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: start=1 -> RUN. On entry to RUN, clear neg_count and both counters, and set busy=1.
  - RUN: issue one read per cycle (addr = read counter) when the issue condition holds. After issuing addr NUM_ELEM-1, go to DRAIN.
  - DRAIN: no reads. Go to DONE when the write of addr NUM_ELEM-1 is accepted.
  - DONE: done=1 and busy=1 for exactly one cycle, then IDLE with busy=0.
- Pipeline:
  - Stage R: the read is issued.
  - Stage D: src_rd_data is returned. It is captured into the output register if the output register is free or being accepted this cycle; otherwise into a 1-entry skid buffer.
  - Stage W: dst_wr_en is asserted from the output register.
- Issue condition: skid buffer empty AND NOT (dst_wr_en && !dst_ready) AND read counter < NUM_ELEM. This guarantees that at most one in-flight read is ever stalled.
- Stall: while dst_wr_en && !dst_ready, dst_wr_en, dst_wr_addr and dst_wr_data hold stable. On acceptance, the skid entry (if any) moves to the output register with priority over new read data.
- ReLU rule:
  - Output = 0 if bit[DATA_W-1] = 1, else input unchanged. Zero passes as zero; 0x8000 becomes 0x0000.
  - neg_count increments when a negative element is accepted into the output register, not when it is written.
- Writes occur in strictly ascending address order, 0..NUM_ELEM-1, with no gaps or duplicates.
- Latency with no stalls:
  - start high at edge k.
  - src_rd_en with addr 0 in cycle k+1.
  - First dst_wr_en in cycle k+3.
  - Last write in cycle k+38.
  - done in cycle k+39.
- start while not in IDLE is ignored. start held high continuously launches a new pass in the cycle after DONE.
- If dst_ready is low indefinitely, the block stalls indefinitely; there is no timeout.

Decomposition:
- Shared package cnn_pkg holds:
  - FM_DIM=6, FM_ELEMS=36, DATA_W=16.
  - The state enum typedef (IDLE, RUN, DRAIN, DONE).
  - A relu_fn function returning the clamped value.
- Sub-module relu_skid_stage: the D/W output register plus the 1-entry skid buffer, with valid/ready on both sides.
- The top level keeps the FSM, the counters and neg_count.

Test Plan:
- Ramp input -18..17 with dst_ready=1 -> writes at addr 0..35; data is 0 for addr 0..18 and 1..17 for addr 19..35; neg_count=18; done in cycle k+39.
- Input includes 0x8000, 0x0000 and 0x7FFF -> written as 0x0000, 0x0000 and 0x7FFF respectively; neg_count counts only 0x8000.
- Random dst_ready (50%) -> all 36 writes in order, each exactly once, data stable during stalls, done one cycle after the last acceptance.
- Hold dst_ready=0 for 10 cycles at addr 5 -> at most one extra read issued (addr 6); addr 5 data held; the sequence resumes correctly.
- Pulse start during RUN -> ignored; exactly one done pulse.
- Deassert rst_n at write 20 -> all outputs 0 immediately; a following start performs a full clean pass from addr 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: feature-map geometry, sequencer states and the ReLU clamp.
package cnn_pkg;

    localparam int unsigned FM_DIM   = 6;
    localparam int unsigned FM_ELEMS = FM_DIM * FM_DIM;
    localparam int unsigned DATA_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Two's-complement clamp: anything with the sign bit set becomes zero.
    function automatic logic [DATA_W-1:0] relu_fn(input logic [DATA_W-1:0] i_x);
        return i_x[DATA_W-1] ? '0 : i_x;
    endfunction

endpackage

// File: rtl/relu_skid_stage.sv
// Output register plus a one-entry skid buffer between the read-return and destination sides.
module relu_skid_stage
    import cnn_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_in_data,
    input  logic         i_in_neg,
    output logic         o_in_ready,
    output logic         o_load,
    output logic         o_load_neg,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    input  logic         i_out_ready
);

    logic         r_out_vld;
    logic [W-1:0] r_out_data;
    logic         r_skid_vld;
    logic         r_skid_neg;
    logic [W-1:0] r_skid_data;
    logic         w_out_free;

    assign w_out_free  = !r_out_vld || i_out_ready;
    assign o_in_ready  = !r_skid_vld;
    // The skid entry is older than the returning read, so it refills the output first.
    assign o_load      = w_out_free && (r_skid_vld || i_in_valid);
    assign o_load_neg  = r_skid_vld ? r_skid_neg : i_in_neg;
    assign o_out_valid = r_out_vld;
    assign o_out_data  = r_out_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld   <= 1'b0;
            r_out_data  <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_neg  <= 1'b0;
            r_skid_data <= '0;
        end else if (w_out_free) begin
            r_out_vld <= r_skid_vld || i_in_valid;
            if (r_skid_vld) begin
                r_out_data  <= r_skid_data;
                r_skid_vld  <= i_in_valid;
                r_skid_data <= i_in_data;
                r_skid_neg  <= i_in_neg;
            end else if (i_in_valid) begin
                r_out_data <= i_in_data;
            end
        end else if (i_in_valid) begin
            r_skid_vld  <= 1'b1;
            r_skid_data <= i_in_data;
            r_skid_neg  <= i_in_neg;
        end
    end

endmodule

// File: rtl/relu_seq_ctrl.sv
// ReLU sequencer: streams one feature map from the source buffer to the destination buffer,
// clamping negatives to zero and counting how many were clipped.
module relu_seq_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W   = cnn_pkg::DATA_W,
    parameter int unsigned NUM_ELEM = cnn_pkg::FM_ELEMS,
    parameter int unsigned ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_src_rd_en,
    output logic [ADDR_W-1:0] o_src_rd_addr,
    input  logic [DATA_W-1:0] i_src_rd_data,
    output logic              o_dst_wr_en,
    output logic [ADDR_W-1:0] o_dst_wr_addr,
    output logic [DATA_W-1:0] o_dst_wr_data,
    input  logic              i_dst_ready,
    output logic [ADDR_W-1:0] o_neg_count
);

    localparam logic [ADDR_W:0]   L_NUM     = (ADDR_W+1)'(NUM_ELEM);
    localparam logic [ADDR_W:0]   L_LAST_RD = (ADDR_W+1)'(NUM_ELEM - 1);
    localparam logic [ADDR_W-1:0] L_LAST_WR = ADDR_W'(NUM_ELEM - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W:0]   r_rd_cnt;
    logic [ADDR_W-1:0] r_wr_cnt;
    logic [ADDR_W-1:0] r_neg_cnt;
    logic              r_rd_vld;

    logic              w_in_ready;
    logic              w_load;
    logic              w_load_neg;
    logic              w_out_vld;
    logic [DATA_W-1:0] w_out_data;
    logic              w_stall;
    logic              w_issue;
    logic              w_accept;
    logic              w_start;

    assign w_stall  = w_out_vld && !i_dst_ready;
    assign w_accept = w_out_vld && i_dst_ready;
    assign w_start  = (r_state == IDLE) && i_start;
    // An empty skid and a moving output guarantee room for the read's return next cycle.
    assign w_issue  = (r_state == RUN) && w_in_ready && !w_stall && (r_rd_cnt < L_NUM);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (w_issue && (r_rd_cnt == L_LAST_RD)) w_state_nxt = DRAIN;
            DRAIN:   if (w_accept && (r_wr_cnt == L_LAST_WR)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rd_cnt  <= '0;
            r_wr_cnt  <= '0;
            r_neg_cnt <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rd_vld <= w_issue;
            if (w_start) begin
                r_rd_cnt  <= '0;
                r_wr_cnt  <= '0;
                r_neg_cnt <= '0;
            end else begin
                if (w_issue)  r_rd_cnt <= r_rd_cnt + (ADDR_W+1)'(1);
                if (w_accept) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                if (w_load && w_load_neg) r_neg_cnt <= r_neg_cnt + ADDR_W'(1);
            end
        end
    end

    relu_skid_stage #(
        .W (DATA_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (r_rd_vld),
        .i_in_data   (relu_fn(i_src_rd_data)),
        .i_in_neg    (i_src_rd_data[DATA_W-1]),
        .o_in_ready  (w_in_ready),
        .o_load      (w_load),
        .o_load_neg  (w_load_neg),
        .o_out_valid (w_out_vld),
        .o_out_data  (w_out_data),
        .i_out_ready (i_dst_ready)
    );

    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == DONE);
    assign o_src_rd_en   = w_issue;
    assign o_src_rd_addr = r_rd_cnt[ADDR_W-1:0];
    assign o_dst_wr_en   = w_out_vld;
    assign o_dst_wr_addr = r_wr_cnt;
    assign o_dst_wr_data = w_out_data;
    assign o_neg_count   = r_neg_cnt;

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Directed bench for relu_seq_ctrl: latency, clamping, backpressure, start filtering, reset.
module tb_relu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dst_ready = 1'b0;
    logic [15:0] src_rd_data = '0;
    logic        busy, done, src_rd_en, dst_wr_en;
    logic [5:0]  src_rd_addr, dst_wr_addr, neg_count;
    logic [15:0] dst_wr_data;

    logic [15:0] src_mem [0:63];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rand_mode = 1'b0;

    // Monitor state, cleared whenever a start is about to be accepted
    int          n_wr = 0;
    logic [5:0]  wr_addr_log [0:63];
    logic [15:0] wr_data_log [0:63];
    int          done_count = 0, done_cyc = 0, last_acc_cyc = 0, start_k = 0;
    int          first_rd_cyc = -1, first_wr_cyc = -1, max_rd = -1, stall_err = 0;
    bit          prev_stall = 1'b0;
    logic [5:0]  prev_addr = '0;
    logic [15:0] prev_data = '0;

    relu_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .o_src_rd_en   (src_rd_en),
        .o_src_rd_addr (src_rd_addr),
        .i_src_rd_data (src_rd_data),
        .o_dst_wr_en   (dst_wr_en),
        .o_dst_wr_addr (dst_wr_addr),
        .o_dst_wr_data (dst_wr_data),
        .i_dst_ready   (dst_ready),
        .o_neg_count   (neg_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (src_rd_en) src_rd_data <= src_mem[src_rd_addr];

    // Cycle labels use cyc+1 so that "edge k" and "cycle k+n" line up with the latency numbers.
    always @(negedge clk) begin
        if (start && !busy && rst_n) begin
            n_wr = 0; done_count = 0; first_rd_cyc = -1; first_wr_cyc = -1;
            max_rd = -1; stall_err = 0; prev_stall = 1'b0; start_k = cyc + 1;
        end else begin
            if (src_rd_en) begin
                if (first_rd_cyc < 0) first_rd_cyc = cyc + 1;
                if (int'(src_rd_addr) > max_rd) max_rd = int'(src_rd_addr);
            end
            if (dst_wr_en && first_wr_cyc < 0) first_wr_cyc = cyc + 1;
            if (prev_stall && !(dst_wr_en && dst_wr_addr == prev_addr && dst_wr_data == prev_data))
                stall_err++;
            prev_stall = dst_wr_en && !dst_ready;
            prev_addr  = dst_wr_addr;
            prev_data  = dst_wr_data;
            if (dst_wr_en && dst_ready) begin
                if (n_wr < 64) begin
                    wr_addr_log[n_wr] = dst_wr_addr;
                    wr_data_log[n_wr] = dst_wr_data;
                end
                n_wr++;
                last_acc_cyc = cyc + 1;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc + 1;
            end
        end
    end

    function automatic logic [15:0] relu_ref(input logic [15:0] x);
        return ($signed(x) < 0) ? 16'h0000 : x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) dst_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        step();
    endtask

    task automatic wait_wr_addr(input string tag, input logic [5:0] addr);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (dst_wr_en && dst_wr_addr == addr) found = 1'b1;
            else step();
        end
        check({tag, "_reach_addr"}, 32'(found), 32'd1);
    endtask

    task automatic check_pass(input string tag, input int exp_neg);
        int bad_addr = 0, bad_data = 0, first_bad = -1;
        check({tag, "_n_writes"}, 32'(n_wr), 32'd36);
        for (int i = 0; i < 36; i++) begin
            if (wr_addr_log[i] !== 6'(i)) begin
                bad_addr++;
                if (first_bad < 0) first_bad = i;
            end
            if (wr_data_log[i] !== relu_ref(src_mem[i])) begin
                bad_data++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (first_bad >= 0)
            $display("note %s first bad write index %0d addr=%0d data=0x%0h src=0x%0h", tag,
                     first_bad, wr_addr_log[first_bad], wr_data_log[first_bad], src_mem[first_bad]);
        check({tag, "_addr_order_bad"}, 32'(bad_addr), 32'd0);
        check({tag, "_data_bad"}, 32'(bad_data), 32'd0);
        check({tag, "_neg_count"}, 32'(neg_count), 32'(exp_neg));
        check({tag, "_done_pulses"}, 32'(done_count), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_en"}, 32'(src_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(src_rd_addr), 32'd0);
        check({tag, "_wr_en"}, 32'(dst_wr_en), 32'd0);
        check({tag, "_wr_addr"}, 32'(dst_wr_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(dst_wr_data), 32'd0);
        check({tag, "_neg_count"}, 32'(neg_count), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) src_mem[i] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Ramp -18..17 with no backpressure; latency against edge k
        for (int i = 0; i < 36; i++) src_mem[i] = 16'(i - 18);
        dst_ready = 1'b1;
        pulse_start();
        wait_done("ramp", 100);
        check_pass("ramp", 18);
        check("ramp_first_rd_lat", 32'(first_rd_cyc - start_k), 32'd1);
        check("ramp_first_wr_lat", 32'(first_wr_cyc - start_k), 32'd3);
        check("ramp_last_wr_lat", 32'(last_acc_cyc - start_k), 32'd38);
        check("ramp_done_lat", 32'(done_cyc - start_k), 32'd39);
        check("ramp_wr19", 32'(wr_data_log[19]), 32'd1);
        check("ramp_wr35", 32'(wr_data_log[35]), 32'd17);

        // Corner values: most-negative, zero, most-positive
        for (int i = 0; i < 36; i++) src_mem[i] = 16'(i * 3 + 1);
        src_mem[3] = 16'h8000;
        src_mem[4] = 16'h0000;
        src_mem[5] = 16'h7FFF;
        pulse_start();
        wait_done("corner", 100);
        check_pass("corner", 1);
        check("corner_8000", 32'(wr_data_log[3]), 32'h0000);
        check("corner_0000", 32'(wr_data_log[4]), 32'h0000);
        check("corner_7fff", 32'(wr_data_log[5]), 32'h7FFF);

        // Random backpressure; every third element negative
        for (int i = 0; i < 36; i++)
            src_mem[i] = (i % 3 == 0) ? 16'(-(i + 1)) : 16'(i * 7);
        rand_mode = 1'b1;
        pulse_start();
        wait_done("rand", 2000);
        rand_mode = 1'b0;
        dst_ready = 1'b1;
        check_pass("rand", 12);
        check("rand_stall_stable_err", 32'(stall_err), 32'd0);
        check("rand_done_after_last", 32'(done_cyc - last_acc_cyc), 32'd1);

        // Long stall on addr 5
        for (int i = 0; i < 36; i++)
            src_mem[i] = (i % 4 == 2) ? 16'(-(i * 100)) : 16'(i * 100 + 7);
        pulse_start();
        wait_wr_addr("stall", 6'd5);
        dst_ready = 1'b0;
        repeat (10) step();
        check("stall_wr_en", 32'(dst_wr_en), 32'd1);
        check("stall_wr_addr", 32'(dst_wr_addr), 32'd5);
        check("stall_wr_data", 32'(dst_wr_data), 32'd507);
        check("stall_rd_en", 32'(src_rd_en), 32'd0);
        check("stall_max_rd", 32'(max_rd), 32'd6);
        dst_ready = 1'b1;
        wait_done("stall", 100);
        check_pass("stall", 9);
        check("stall_stable_err", 32'(stall_err), 32'd0);

        // Start pulsed mid-run must be ignored
        pulse_start();
        repeat (10) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("restart", 100);
        check_pass("restart", 9);
        repeat (5) step();
        check("restart_single_done", 32'(done_count), 32'd1);
        check("restart_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset at write 20, then a clean pass
        pulse_start();
        wait_wr_addr("rstmid", 6'd20);
        rst_n = 1'b0;
        #1;
        check_all_zero("rstmid");
        step();
        step();
        rst_n = 1'b1;
        step();
        pulse_start();
        wait_done("after_rst", 100);
        check_pass("after_rst", 9);
        check("after_rst_first_rd_lat", 32'(first_rd_cyc - start_k), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
